// File: rtl/seq_array_multiplier.sv
// Folded array multiplier: ROWS_PER_CYCLE partial-product rows are accumulated per BUSY cycle,
// with valid/ready on both sides and per-transaction signed/unsigned operands.

module seq_array_row #(
  parameter int W2 = 16,
  parameter int IW = 4
) (
  input  logic [W2-1:0] a_ext,
  input  logic          b_bit,
  input  logic [IW-1:0] idx,
  input  logic          neg,
  output logic [W2-1:0] term
);
  logic [W2-1:0] row;

  // The signed MSB row carries weight -2^(WIDTH-1), so it enters the sum negated.
  always_comb begin
    row  = b_bit ? (a_ext << idx) : '0;
    term = neg ? (~row + W2'(1)) : row;
  end
endmodule

module seq_array_multiplier #(
  parameter int WIDTH          = 8,
  parameter int ROWS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p
);
  localparam int W2 = 2 * WIDTH;
  localparam int R  = ROWS_PER_CYCLE;
  localparam int CW = $clog2(WIDTH + 1);

  generate
    if (WIDTH < 2 || R < 1 || R > WIDTH || (WIDTH % R) != 0) begin : g_bad_cfg
      $error("seq_array_multiplier: illegal WIDTH/ROWS_PER_CYCLE combination");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q, b_q;
  logic                 sm_q;
  logic [W2-1:0]        acc, a_ext, sum;
  logic [CW-1:0]        cnt;
  logic [R-1:0][W2-1:0] terms;
  logic                 last;

  assign a_ext = sm_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
  assign last  = (cnt == CW'(WIDTH - R));

  for (genvar k = 0; k < R; k++) begin : g_lane
    logic [CW-1:0] idx;
    logic          b_bit;
    assign idx   = cnt + CW'(k);
    assign b_bit = |(b_q & (WIDTH'(1) << idx));
    seq_array_row #(.W2(W2), .IW(CW)) u_row (
      .a_ext (a_ext),
      .b_bit (b_bit),
      .idx   (idx),
      .neg   (sm_q && (idx == CW'(WIDTH - 1))),
      .term  (terms[k])
    );
  end

  always_comb begin
    sum = '0;
    for (int k = 0; k < R; k++) sum = sum + terms[k];
  end

  // Handshake outputs come from the state register; rst only forces them low.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = !rst;
        if (in_valid) state_d = BUSY;
      end
      BUSY: if (last) state_d = DONE;
      DONE: begin
        out_valid = !rst;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) state_d = IDLE;
  end

  assign p = rst ? '0 : acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sm_q    <= 1'b0;
      acc     <= '0;
      cnt     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (in_valid) begin
          a_q  <= a;
          b_q  <= b;
          sm_q <= signed_mode;
          acc  <= '0;
          cnt  <= '0;
        end
        BUSY: begin
          acc <= acc + sum;
          cnt <= cnt + CW'(R);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_array_multiplier.sv
// Directed and randomized checks of seq_array_multiplier across several WIDTH/ROWS_PER_CYCLE builds.

module tb_seq_array_multiplier;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   checks = 0, errors = 0;
  logic start_rand = 1'b0;
  int   rand_done = 0;

  // W8 R1
  logic d1_iv, d1_ir, d1_sm, d1_ov, d1_or;
  logic [7:0] d1_a, d1_b;
  logic [15:0] d1_p;
  seq_array_multiplier #(.WIDTH(8), .ROWS_PER_CYCLE(1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(d1_iv), .in_ready(d1_ir), .a(d1_a), .b(d1_b),
    .signed_mode(d1_sm), .out_valid(d1_ov), .out_ready(d1_or), .p(d1_p));

  // W8 R4
  logic d4_iv, d4_ir, d4_sm, d4_ov, d4_or;
  logic [7:0] d4_a, d4_b;
  logic [15:0] d4_p;
  seq_array_multiplier #(.WIDTH(8), .ROWS_PER_CYCLE(4)) u_d4 (
    .clk(clk), .rst(rst), .in_valid(d4_iv), .in_ready(d4_ir), .a(d4_a), .b(d4_b),
    .signed_mode(d4_sm), .out_valid(d4_ov), .out_ready(d4_or), .p(d4_p));

  // W16 R2
  logic dc_iv, dc_ir, dc_sm, dc_ov, dc_or;
  logic [15:0] dc_a, dc_b;
  logic [31:0] dc_p;
  seq_array_multiplier #(.WIDTH(16), .ROWS_PER_CYCLE(2)) u_dc (
    .clk(clk), .rst(rst), .in_valid(dc_iv), .in_ready(dc_ir), .a(dc_a), .b(dc_b),
    .signed_mode(dc_sm), .out_valid(dc_ov), .out_ready(dc_or), .p(dc_p));

  localparam int NCFG = 11;
  localparam int CFG_W [NCFG] = '{2, 2, 8, 8, 8, 8, 16, 16, 16, 16, 16};
  localparam int CFG_R [NCFG] = '{1, 2, 1, 2, 4, 8, 1, 2, 4, 8, 16};

  for (genvar g = 0; g < NCFG; g++) begin : g_rand
    localparam int W = CFG_W[g];
    localparam int R = CFG_R[g];
    logic iv, ir, sm, ov, ordy;
    logic [W-1:0] x, y;
    logic [2*W-1:0] p, expp, pg, ax, by;
    int guard, first;
    logic got;

    seq_array_multiplier #(.WIDTH(W), .ROWS_PER_CYCLE(R)) u_dut (
      .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .a(x), .b(y),
      .signed_mode(sm), .out_valid(ov), .out_ready(ordy), .p(p));

    initial begin
      iv = 1'b0; x = '0; y = '0; sm = 1'b0; ordy = 1'b0;
      wait (start_rand);
      for (int t = 0; t < 20; t++) begin
        @(negedge clk);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        x  = W'($urandom);
        y  = W'($urandom);
        sm = 1'($urandom);
        ax = sm ? {{W{x[W-1]}}, x} : {{W{1'b0}}, x};
        by = sm ? {{W{y[W-1]}}, y} : {{W{1'b0}}, y};
        expp = ax * by;
        iv = 1'b1;
        checks++;
        if (ir !== 1'b1) begin
          errors++;
          $display("FAIL rand_accept W%0d R%0d: in_ready=%b expected 1", W, R, ir);
        end
        @(negedge clk);
        iv = 1'b0;
        x  = W'($urandom);
        y  = W'($urandom);
        sm = 1'($urandom);
        got = 1'b0; guard = 0; first = -1; pg = '0;
        while (!got && guard < 300) begin
          ordy = 1'($urandom);
          if (ov === 1'b1 && first < 0) first = guard;
          if (ov === 1'b1 && ordy) begin
            got = 1'b1;
            pg  = p;
          end
          @(negedge clk);
          guard++;
        end
        ordy = 1'b0;
        checks++;
        if (first != W / R) begin
          errors++;
          $display("FAIL rand_latency W%0d R%0d: got %0d expected %0d", W, R, first, W / R);
        end
        checks++;
        if (!got || pg !== expp) begin
          errors++;
          $display("FAIL rand_product W%0d R%0d: got %h (handshake=%b) expected %h", W, R, pg, got, expp);
        end
        checks++;
        if (ov !== 1'b0) begin
          errors++;
          $display("FAIL rand_dup W%0d R%0d: out_valid=%b expected 0 after handshake", W, R, ov);
        end
      end
      rand_done++;
    end
  end

  task automatic op1(input logic [7:0] x, input logic [7:0] y, input logic sm,
                     input logic [15:0] exp, input string nm);
    int lat;
    @(negedge clk);
    d1_a = x; d1_b = y; d1_sm = sm; d1_iv = 1'b1; d1_or = 1'b1;
    checks++;
    if (d1_ir !== 1'b1) begin
      errors++;
      $display("FAIL %s_accept: in_ready=%b expected 1", nm, d1_ir);
    end
    @(negedge clk);
    d1_iv = 1'b0; d1_a = ~x; d1_b = ~y; d1_sm = ~sm;
    checks++;
    if (d1_ir !== 1'b0 || d1_ov !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy: in_ready=%b out_valid=%b expected 0 0", nm, d1_ir, d1_ov);
    end
    lat = 0;
    while (d1_ov !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != 8) begin
      errors++;
      $display("FAIL %s_latency: got %0d expected 8", nm, lat);
    end
    checks++;
    if (d1_p !== exp) begin
      errors++;
      $display("FAIL %s_product: got %h expected %h", nm, d1_p, exp);
    end
    @(negedge clk);
    checks++;
    if (d1_ov !== 1'b0 || d1_ir !== 1'b1) begin
      errors++;
      $display("FAIL %s_release: out_valid=%b in_ready=%b expected 0 1", nm, d1_ov, d1_ir);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (d1_ir !== 1'b0 || d1_ov !== 1'b0 || d1_p !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: in_ready=%b out_valid=%b p=%h expected 0 0 0000", d1_ir, d1_ov, d1_p);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (d1_ir !== 1'b1 || d1_ov !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b expected 1 0", d1_ir, d1_ov);
    end
  endtask

  task automatic test_modes();
    logic [7:0]  ta [3] = '{8'h80, 8'hFF, 8'h7F};
    logic [7:0]  tb [3] = '{8'h80, 8'h01, 8'h80};
    logic [15:0] es [3] = '{16'h4000, 16'hFFFF, 16'hC080};
    logic [15:0] eu [3] = '{16'h4000, 16'h00FF, 16'h3F80};
    op1(8'hFF, 8'hFF, 1'b0, 16'hFE01, "unsigned_max");
    for (int i = 0; i < 3; i++) begin
      op1(ta[i], tb[i], 1'b1, es[i], $sformatf("signed%0d", i));
      op1(ta[i], tb[i], 1'b0, eu[i], $sformatf("unsigned%0d", i));
    end
  endtask

  task automatic test_fold();
    int lat;
    @(negedge clk);
    d4_a = 8'd13; d4_b = 8'd11; d4_sm = 1'b0; d4_iv = 1'b1; d4_or = 1'b1;
    @(negedge clk);
    d4_iv = 1'b0;
    lat = 0;
    while (d4_ov !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != 2) begin
      errors++;
      $display("FAIL fold_r4_latency: got %0d expected 2", lat);
    end
    checks++;
    if (d4_p !== 16'h008F) begin
      errors++;
      $display("FAIL fold_r4_product: got %h expected 008f", d4_p);
    end
    @(negedge clk);
    checks++;
    if (d4_ov !== 1'b0 || d4_ir !== 1'b1) begin
      errors++;
      $display("FAIL fold_r4_release: out_valid=%b in_ready=%b expected 0 1", d4_ov, d4_ir);
    end

    @(negedge clk);
    dc_a = 16'hFFFF; dc_b = 16'hFFFF; dc_sm = 1'b1; dc_iv = 1'b1; dc_or = 1'b1;
    @(negedge clk);
    dc_iv = 1'b0;
    lat = 0;
    while (dc_ov !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != 8) begin
      errors++;
      $display("FAIL fold_w16_latency: got %0d expected 8", lat);
    end
    checks++;
    if (dc_p !== 32'h0000_0001) begin
      errors++;
      $display("FAIL fold_w16_product: got %h expected 00000001", dc_p);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int lat;
    @(negedge clk);
    d1_a = 8'h12; d1_b = 8'h34; d1_sm = 1'b0; d1_iv = 1'b1; d1_or = 1'b0;
    @(negedge clk);
    d1_iv = 1'b0;
    lat = 0;
    while (d1_ov !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (d1_ov !== 1'b1 || d1_p !== 16'h03A8) begin
      errors++;
      $display("FAIL bp_product: out_valid=%b p=%h expected 1 03a8", d1_ov, d1_p);
    end
    d1_iv = 1'b1; d1_a = 8'd3; d1_b = 8'd5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (d1_ov !== 1'b1 || d1_p !== 16'h03A8 || d1_ir !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: out_valid=%b p=%h in_ready=%b expected 1 03a8 0", i, d1_ov, d1_p, d1_ir);
      end
    end
    d1_or = 1'b1;
    @(negedge clk);
    checks++;
    if (d1_ov !== 1'b0 || d1_ir !== 1'b1) begin
      errors++;
      $display("FAIL bp_single_transfer: out_valid=%b in_ready=%b expected 0 1", d1_ov, d1_ir);
    end
    @(negedge clk);
    d1_iv = 1'b0;
    checks++;
    if (d1_ir !== 1'b0) begin
      errors++;
      $display("FAIL bp_next_accept: in_ready=%b expected 0", d1_ir);
    end
    lat = 0;
    while (d1_ov !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != 8 || d1_p !== 16'd15) begin
      errors++;
      $display("FAIL bp_next_product: latency=%0d p=%h expected 8 000f", lat, d1_p);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic seen;
    @(negedge clk);
    d1_a = 8'h55; d1_b = 8'h66; d1_sm = 1'b0; d1_iv = 1'b1; d1_or = 1'b1;
    @(negedge clk);
    d1_iv = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (d1_ir !== 1'b1 || d1_ov !== 1'b0) begin
      errors++;
      $display("FAIL midreset_idle: in_ready=%b out_valid=%b expected 1 0", d1_ir, d1_ov);
    end
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (d1_ov === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL midreset_no_output: out_valid pulsed=%b expected 0", seen);
    end
    op1(8'd3, 8'd5, 1'b0, 16'd15, "post_reset");
  endtask

  initial begin
    int w;
    rst = 1'b1;
    d1_iv = 1'b0; d1_a = '0; d1_b = '0; d1_sm = 1'b0; d1_or = 1'b0;
    d4_iv = 1'b0; d4_a = '0; d4_b = '0; d4_sm = 1'b0; d4_or = 1'b0;
    dc_iv = 1'b0; dc_a = '0; dc_b = '0; dc_sm = 1'b0; dc_or = 1'b0;
    test_reset();
    test_modes();
    test_fold();
    test_backpressure();
    test_reset_mid();
    start_rand = 1'b1;
    w = 0;
    while (rand_done != NCFG && w < 20000) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (rand_done != NCFG) begin
      errors++;
      $display("FAIL rand_timeout: finished %0d of %0d configs", rand_done, NCFG);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
